// File: rtl/franken_mem_pkg.sv
// Shared decode constants and UART state type for the data-side memory bus.
package franken_mem_pkg;
  localparam logic [3:0] RAM_REGION  = 4'h0;
  localparam logic [3:0] MMIO_REGION = 4'h8;

  // MMIO register offsets as word indices (addr[4:2])
  localparam logic [2:0] OFF_LED    = 3'd0;
  localparam logic [2:0] OFF_UART   = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_CMP    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/franken_uart_tx.sv
// 8N1 transmitter: start bit, 8 data bits LSB first, stop bit, DIV cycles each.
module franken_uart_tx
  import franken_mem_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o
);
  localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  uart_state_t   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign tick = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    baud_d  = '0;
    if (state_q != IDLE) baud_d = tick ? '0 : baud_q + BW'(1);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = START;
          shift_d = data_i;
          bit_d   = '0;
        end
      end
      START: if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      START:   tx_o = 1'b0;
      DATA:    tx_o = shift_q[0];
      default: tx_o = 1'b1;
    endcase
  end

  assign busy_o = (state_q != IDLE);
endmodule

// File: rtl/franken_dmem_bus.sv
// Core data port: byte-enabled RAM plus MMIO page (LEDs, timer/compare, UART TX).
module franken_dmem_bus
  import franken_mem_pkg::*;
#(
  parameter int RAM_ADDR_BITS = 10,
  parameter int UART_DIV      = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        mem_write,
  input  logic [3:0]  byte_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [7:0]  leds,
  output logic        uart_tx,
  output logic        timer_irq
);
  logic [31:0] ram_q [2**RAM_ADDR_BITS];
  logic [RAM_ADDR_BITS-1:0] widx;
  logic [2:0]  off;
  logic        is_ram, is_mmio, mmio_we, uart_start, uart_busy;
  logic [7:0]  leds_q, leds_d;
  logic [31:0] count_q, count_d, cmp_q, cmp_d;
  logic        flag_q, flag_d;
  logic        unused_addr_bits;

  assign widx    = addr[RAM_ADDR_BITS+1:2];
  assign off     = addr[4:2];
  assign is_ram  = (addr[31:28] == RAM_REGION);
  assign is_mmio = (addr[31:28] == MMIO_REGION);
  // Sub-word stores never reach MMIO registers
  assign mmio_we    = mem_write && is_mmio && (byte_enable == 4'hF);
  assign uart_start = mmio_we && (off == OFF_UART);
  assign unused_addr_bits = ^{addr[27:RAM_ADDR_BITS+2], addr[1:0]};

  always_ff @(posedge clk) begin
    if (mem_write && is_ram)
      for (int i = 0; i < 4; i++)
        if (byte_enable[i]) ram_q[widx][8*i +: 8] <= write_data[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q  <= '0;
      count_q <= '0;
      cmp_q   <= '1;
      flag_q  <= 1'b0;
    end else begin
      leds_q  <= leds_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    leds_d  = leds_q;
    cmp_d   = cmp_q;
    count_d = count_q + 32'd1;
    flag_d  = flag_q;
    if (mmio_we) begin
      case (off)
        OFF_LED:    leds_d  = write_data[7:0];
        OFF_COUNT:  count_d = write_data;
        OFF_CMP:    cmp_d   = write_data;
        OFF_STATUS: if (write_data[0]) flag_d = 1'b0;
        default: ;
      endcase
    end
    // A match on the same edge as a W1C clear keeps the flag set
    if (count_q == cmp_q) flag_d = 1'b1;
  end

  always_comb begin
    read_data = '0;
    if (is_ram) begin
      read_data = ram_q[widx];
    end else if (is_mmio) begin
      case (off)
        OFF_LED:    read_data = {24'b0, leds_q};
        OFF_UART:   read_data = {31'b0, uart_busy};
        OFF_COUNT:  read_data = count_q;
        OFF_CMP:    read_data = cmp_q;
        OFF_STATUS: read_data = {31'b0, flag_q};
        default:    read_data = '0;
      endcase
    end
  end

  franken_uart_tx #(.DIV(UART_DIV)) u_uart (
    .clk     (clk),
    .reset   (reset),
    .start_i (uart_start),
    .data_i  (write_data[7:0]),
    .tx_o    (uart_tx),
    .busy_o  (uart_busy)
  );

  assign leds      = leds_q;
  assign timer_irq = flag_q;
endmodule

// File: tb/tb_franken_dmem_bus.sv
// Vector table, hand sequences and random traffic against a transaction-level model.
module tb_franken_dmem_bus;
  localparam int DIV = 4;
  localparam logic [31:0] LED_A = 32'h8000_0000, UART_A = 32'h8000_0004,
                          CNT_A = 32'h8000_0008, CMP_A  = 32'h8000_000C,
                          STS_A = 32'h8000_0010;

  logic        clk = 1'b0, reset = 1'b1, mem_write = 1'b0;
  logic [31:0] addr = '0, write_data = '0;
  logic [3:0]  byte_enable = '0;
  logic [31:0] read_data;
  logic [7:0]  leds;
  logic        uart_tx, timer_irq;

  franken_dmem_bus #(.RAM_ADDR_BITS(10), .UART_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .addr(addr), .mem_write(mem_write),
    .byte_enable(byte_enable), .write_data(write_data), .read_data(read_data),
    .leds(leds), .uart_tx(uart_tx), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  // Reference model state
  logic [7:0]  m_mem [int];
  logic [7:0]  m_leds;
  logic [31:0] m_count, m_cmp;
  logic        m_flag;
  int          m_left;
  logic [9:0]  m_frame;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_leds = 0; m_count = 0; m_cmp = '1; m_flag = 0; m_left = 0; m_frame = '0;
  endtask

  task automatic model_read(input logic [31:0] a, output logic [31:0] v, output bit known);
    v = '0; known = 1;
    if (a[31:28] == 4'h0) begin
      for (int l = 0; l < 4; l++) begin
        int key = int'(a[11:2]) * 4 + l;
        if (m_mem.exists(key)) v[8*l +: 8] = m_mem[key];
        else known = 0;
      end
    end else if (a[31:28] == 4'h8) begin
      case (a[4:2])
        3'd0: v = {24'b0, m_leds};
        3'd1: v = {31'b0, 1'(m_left != 0)};
        3'd2: v = m_count;
        3'd3: v = m_cmp;
        3'd4: v = {31'b0, m_flag};
        default: v = '0;
      endcase
    end
  endtask

  function automatic logic model_tx();
    if (m_left == 0) return 1'b1;
    return m_frame[(10*DIV - m_left) / DIV];
  endfunction

  task automatic model_update(input logic we, input logic [3:0] be,
                              input logic [31:0] a, input logic [31:0] wd);
    logic mw, nf;
    logic [31:0] nc;
    mw = we && a[31:28] == 4'h8 && be == 4'hF;
    if (we && a[31:28] == 4'h0)
      for (int l = 0; l < 4; l++)
        if (be[l]) m_mem[int'(a[11:2]) * 4 + l] = wd[8*l +: 8];
    nf = (m_count == m_cmp) || (m_flag && !(mw && a[4:2] == 3'd4 && wd[0]));
    nc = (mw && a[4:2] == 3'd2) ? wd : m_count + 1;
    if (mw && a[4:2] == 3'd0) m_leds = wd[7:0];
    if (mw && a[4:2] == 3'd3) m_cmp = wd;
    if (mw && a[4:2] == 3'd1 && m_left == 0) begin
      m_left = 10 * DIV;
      m_frame = {1'b1, wd[7:0], 1'b0};
    end else if (m_left > 0) m_left--;
    m_flag = nf;
    m_count = nc;
  endtask

  // One bus cycle: called just after a negedge, returns at the next negedge
  task automatic apply(input logic we, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic txs);
    logic [31:0] ev;
    bit known;
    mem_write = we; byte_enable = be; addr = a; write_data = wd;
    #1;
    rd = read_data; txs = uart_tx;
    model_read(a, ev, known);
    if (known) chk("model read_data", read_data, ev);
    chk("model leds", {24'b0, leds}, {24'b0, m_leds});
    chk("model timer_irq", {31'b0, timer_irq}, {31'b0, m_flag});
    chk("model uart_tx", {31'b0, uart_tx}, {31'b0, model_tx()});
    @(posedge clk);
    model_update(we, be, a, wd);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    reset = 1; mem_write = 0; byte_enable = '0; write_data = '0; addr = CNT_A;
    @(posedge clk); #1;
    chk({tag, " count"}, read_data, 32'h0);
    chk({tag, " uart_tx"}, {31'b0, uart_tx}, 32'h1);
    chk({tag, " leds"}, {24'b0, leds}, 32'h0);
    chk({tag, " timer_irq"}, {31'b0, timer_irq}, 32'h0);
    addr = CMP_A; #1;
    chk({tag, " cmp"}, read_data, 32'hFFFF_FFFF);
    addr = UART_A; #1;
    chk({tag, " busy"}, read_data, 32'h0);
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  typedef struct {
    logic we; logic [3:0] be; logic [31:0] a; logic [31:0] wd; bit ck; logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [3:0] be, input logic [31:0] a,
                              input logic [31:0] wd, input bit ck, input logic [31:0] exp);
    vec_t v;
    v.we = we; v.be = be; v.a = a; v.wd = wd; v.ck = ck; v.exp = exp;
    return v;
  endfunction

  task automatic run_random();
    logic [31:0] a, wd, rd;
    logic [3:0]  be;
    logic        we, txs;
    logic [2:0]  off;
    int          k, sel;
    for (int i = 0; i < 16; i++) apply(1, 4'hF, 32'(i * 4), $urandom, rd, txs);
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      wd = $urandom; we = 1'($urandom_range(0, 1)); be = 4'hF;
      if (k < 4) begin
        a = {4'h0, 16'($urandom), 6'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
        be = 4'($urandom);
      end else if (k < 7) begin
        sel = $urandom_range(0, 3);
        off = (sel == 0) ? 3'd0 : (sel == 1) ? 3'd2 : (sel == 2) ? 3'd3 : 3'd4;
        a = {4'h8, 23'($urandom), off, 2'b00};
        if (off == 3'd3) wd = m_count + 32'($urandom_range(1, 6));
        if ($urandom_range(0, 4) == 0) be = 4'($urandom);
      end else if (k == 7) begin
        a = $urandom;
        if (a[31:28] == 4'h0 || a[31:28] == 4'h8) a[31:28] = 4'h3;
      end else begin
        a = {4'h8, 23'($urandom), 3'($urandom), 2'b00};
        we = 0;
      end
      apply(we, be, a, wd, rd, txs);
    end
  endtask

  initial begin
    vec_t tbl[$];
    logic [31:0] rd;
    logic        txs, exp_tx;
    logic [7:0]  pat;

    model_reset();
    @(negedge clk);
    do_reset("por");

    tbl.push_back(mk(1, 4'hF, 32'h10,        32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(1, 4'hF, 32'h14,        32'h12345678, 0, 0));
    tbl.push_back(mk(0, 4'hF, 32'h10,        0, 1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 4'hF, 32'h14,        0, 1, 32'h12345678));
    tbl.push_back(mk(1, 4'h4, 32'h12,        32'h00AA0000, 1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 4'hF, 32'h10,        0, 1, 32'hDEAABEEF));
    tbl.push_back(mk(0, 4'hF, 32'h1010,      0, 1, 32'hDEAABEEF));
    tbl.push_back(mk(1, 4'hF, LED_A,         32'h1A5, 1, 32'h0));
    tbl.push_back(mk(0, 4'hF, LED_A,         0, 1, 32'hA5));
    tbl.push_back(mk(1, 4'h1, LED_A,         32'hFF, 1, 32'hA5));
    tbl.push_back(mk(0, 4'hF, LED_A,         0, 1, 32'hA5));
    tbl.push_back(mk(0, 4'hF, 32'h9000_0000, 0, 1, 32'h0));
    tbl.push_back(mk(1, 4'hF, 32'h9000_0000, 32'h5, 1, 32'h0));
    tbl.push_back(mk(0, 4'hF, 32'h8000_0014, 0, 1, 32'h0));
    tbl.push_back(mk(0, 4'hF, 32'h8000_001C, 0, 1, 32'h0));
    tbl.push_back(mk(0, 4'hF, UART_A,        0, 1, 32'h0));
    foreach (tbl[i]) begin
      apply(tbl[i].we, tbl[i].be, tbl[i].a, tbl[i].wd, rd, txs);
      if (tbl[i].ck) chk($sformatf("vec%0d read_data", i), rd, tbl[i].exp);
    end
    chk("leds after sb", {24'b0, leds}, 32'hA5);

    // Timer: COUNT=0 then CMP=20; flag visible while COUNT reads 21
    apply(1, 4'hF, CNT_A, 32'd0, rd, txs);
    apply(1, 4'hF, CMP_A, 32'd20, rd, txs);
    for (int k = 1; k <= 22; k++) begin
      apply(0, 4'hF, CNT_A, 0, rd, txs);
      chk($sformatf("count k=%0d", k), rd, 32'(k));
    end
    apply(0, 4'hF, STS_A, 0, rd, txs);
    chk("irq after match", {31'b0, timer_irq}, 32'h1);
    // Clear colliding with a match: set wins
    apply(1, 4'hF, CNT_A, 32'd19, rd, txs);
    apply(0, 4'hF, CNT_A, 0, rd, txs);
    apply(1, 4'hF, STS_A, 32'h1, rd, txs);
    chk("irq set wins", {31'b0, timer_irq}, 32'h1);
    apply(1, 4'hF, STS_A, 32'h1, rd, txs);
    apply(0, 4'hF, STS_A, 0, rd, txs);
    chk("status after w1c", rd, 32'h0);
    chk("irq after w1c", {31'b0, timer_irq}, 32'h0);
    // Wrap
    apply(1, 4'hF, CNT_A, 32'hFFFF_FFFF, rd, txs);
    apply(0, 4'hF, CNT_A, 0, rd, txs);
    chk("count max", rd, 32'hFFFF_FFFF);
    apply(0, 4'hF, CNT_A, 0, rd, txs);
    chk("count wrap", rd, 32'h0);

    // UART frame of 0x55 with writes dropped mid-frame and as STOP ends
    pat = 8'h55;
    apply(1, 4'hF, UART_A, 32'h55, rd, txs);
    for (int c = 0; c < 42; c++) begin
      apply(c == 10 || c == 39, 4'hF, UART_A, (c == 10) ? 32'h00 : 32'h0F, rd, txs);
      if (c < 4) exp_tx = 1'b0;
      else if (c < 36) exp_tx = pat[(c - 4) / 4];
      else exp_tx = 1'b1;
      chk($sformatf("uart tx c=%0d", c), {31'b0, txs}, {31'b0, exp_tx});
      chk($sformatf("uart busy c=%0d", c), rd, {31'b0, 1'(c < 40)});
    end

    // Reset mid-frame with LEDs lit and flag set
    apply(1, 4'hF, LED_A, 32'hFF, rd, txs);
    apply(1, 4'hF, CNT_A, 32'd100, rd, txs);
    apply(1, 4'hF, CMP_A, 32'd101, rd, txs);
    apply(0, 4'hF, STS_A, 0, rd, txs);
    apply(1, 4'hF, UART_A, 32'h33, rd, txs);
    for (int c = 0; c < 8; c++) apply(0, 4'hF, UART_A, 0, rd, txs);
    chk("pre-reset irq", {31'b0, timer_irq}, 32'h1);
    chk("pre-reset busy", rd, 32'h1);
    do_reset("mid");

    run_random();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/franken_dmem_bus.md
Name: franken_dmem_bus

Overview:
- Data-side memory subsystem directly downstream of the single-cycle core's load/store port.
- Inputs per cycle: address (core alu_result), write_data, byte_enable and mem_write. Output: read_data.
- Contains a byte-enabled data RAM plus an MMIO page with an LED register, a cycle timer with compare/irq, and an 8N1 UART transmitter.
- Reads are combinational because the core completes loads in the same cycle.

Parameters:
- RAM_ADDR_BITS, 10, word-address width; RAM holds 2**RAM_ADDR_BITS 32-bit words.
- UART_DIV, 434, clock cycles per UART bit; legal range is 2 and up.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  byte address from the core.
- mem_write  in  1  store strobe.
- byte_enable  in  4  lane enables; bit i covers write_data[8i+7:8i].
- write_data  in  32  store data, already lane-aligned by the core.
- read_data  out  32  load data, full word; the core selects the lane.
- leds  out  8  LED register.
- uart_tx  out  1  serial output, idles high.
- timer_irq  out  1  sticky timer match flag.

Behaviour:
- Address decode:
  - RAM when addr[31:28]==0. Word index is addr[RAM_ADDR_BITS+1:2]; upper bits alias.
  - MMIO when addr[31:28]==4'h8, decoded on addr[4:2].
  - All other addresses: reads return 0, writes are ignored.
- RAM:
  - Write at posedge when mem_write is high; only enabled lanes update.
  - Read is asynchronous. A same-cycle read of the address being written returns the old word.
  - RAM is not cleared by reset; contents are X until written.
- MMIO writes take effect only when mem_write=1 and byte_enable==4'b1111. Sub-word stores to MMIO are ignored.
- MMIO map, with offset, access and meaning:
  - 0x00 LED, R/W: bits [7:0]; reads zero-extended.
  - 0x04 UART, W/R: a write loads write_data[7:0] and starts a frame if idle; the write is dropped if busy. Read returns {31'b0, busy}.
  - 0x08 COUNT, R/W: a write loads write_data.
  - 0x0C CMP, R/W: compare value.
  - 0x10 STATUS, R/W1C: bit0 is the match flag; writing bit0=1 clears it.
  - Unmapped offsets 0x14–0x1C read 0.
- Timer:
  - COUNT increments every cycle and wraps 0xFFFFFFFF→0.
  - A COUNT write in the same cycle overrides the increment; the next cycle shows the written value.
  - The flag sets on the edge after COUNT==CMP is observed.
  - If set and W1C clear happen in the same cycle, set wins.
  - timer_irq = flag.
- UART TX is an FSM with states IDLE, START, DATA, STOP:
  - Baud counter runs 0..UART_DIV-1; each state or bit lasts exactly UART_DIV cycles.
  - START drives 0. DATA sends 8 bits LSB first. STOP drives 1.
  - After STOP the FSM returns to IDLE.
  - busy=1 in every state except IDLE. A start write in the cycle STOP ends is dropped.
  - Frame length is 10*UART_DIV cycles. The first start bit appears on the cycle after the accepting edge.
- Reset values:
  - leds=0, COUNT=0, CMP=0xFFFFFFFF, flag=0, timer_irq=0.
  - UART state IDLE, uart_tx=1, busy=0, baud counter and bit index 0.
- Reset mid-frame aborts the frame immediately; uart_tx=1 on the next cycle.
- read_data is purely combinational from addr and current state. It is independent of mem_write.

Decomposition:
- Package franken_mem_pkg holds:
  - region constants RAM_REGION=4'h0 and MMIO_REGION=4'h8;
  - MMIO offsets OFF_LED, OFF_UART, OFF_COUNT, OFF_CMP, OFF_STATUS;
  - the UART state enum uart_state_t.
- One sub-module, franken_uart_tx, owns the FSM, baud counter, shift register and busy.
- Decode, RAM, LED and timer logic live in the top block.

Test Plan:
- RAM word write: sw 0xDEADBEEF to 0x00000010, then read 0x10 → 0xDEADBEEF. Read 0x14 after writing it → independent value.
- RAM byte lanes: after the word write, sb with byte_enable=4'b0100 and write_data=0x00AA0000 at 0x12 → read 0x10 returns 0xDEAABEEF.
- LED MMIO:
  - write 0x000001A5 to 0x80000000 → leds=0xA5, read returns 0x000000A5;
  - sb to 0x80000000 → leds unchanged;
  - read 0x90000000 → 0.
- Timer:
  - write CMP=20 and COUNT=0 → timer_irq rises when COUNT is 21;
  - W1C write of 1 to STATUS → irq=0;
  - COUNT=0xFFFFFFFF → next cycle reads 0.
- UART with UART_DIV=4:
  - write 0x55 → uart_tx is 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles; busy is high for 40 cycles;
  - a second write during the frame → dropped.
- Reset during the UART DATA state, and with leds=0xFF and the flag set → next cycle uart_tx=1, busy=0, leds=0, timer_irq=0, COUNT=0.
